lsb_stego_seq: RTL and testbench

LSB_STEGO_SEQ -- requirements
Module: lsb_stego_seq

---
 rtl/lsb_stego_seq.sv | 151 +++++++++++++++
 tb/tb_lsb_stego_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsb_stego_seq.sv
// LSB steganography engine: embeds or extracts NLSB bits per sample, one sample per cycle.
// Optional mismatch counter output enabled by macro LSB_STEGO_DIFFCNT_EN.
`default_nettype none

module lsb_stego_seq #(
  parameter int FRAME_SIZE = 1,
  parameter int BPS        = 8,
  parameter int NLSB       = 1
) (
  input  logic                        in_clk,
  input  logic                        in_rst_n,
  input  logic                        in_enable,
  input  logic                        in_mode,
  input  logic [FRAME_SIZE*BPS-1:0]   in_frame,
  input  logic [FRAME_SIZE*NLSB-1:0]  in_message,
  output logic [FRAME_SIZE*BPS-1:0]   out_frame,
  output logic [FRAME_SIZE*NLSB-1:0]  out_message,
  output logic                        out_ready,
`ifdef LSB_STEGO_DIFFCNT_EN
  output logic [$clog2(FRAME_SIZE*NLSB+1)-1:0] out_diff_cnt,
`endif
  output logic                        out_busy
);

  localparam int IW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(FRAME_SIZE - 1);

  if (NLSB < 1 || NLSB > BPS) begin : g_bad_nlsb
    $error("lsb_stego_seq: NLSB must be in 1..BPS");
  end
  if (FRAME_SIZE < 1 || FRAME_SIZE > 256) begin : g_bad_frame
    $error("lsb_stego_seq: FRAME_SIZE must be in 1..256");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         mode_q, mode_d;
  logic [FRAME_SIZE*BPS-1:0]    work_q, work_d;
  logic [FRAME_SIZE*NLSB-1:0]   msg_q, msg_d;
  logic [FRAME_SIZE*BPS-1:0]    out_frame_q, out_frame_d;
  logic [FRAME_SIZE*NLSB-1:0]   out_msg_q, out_msg_d;
`ifdef LSB_STEGO_DIFFCNT_EN
  localparam int DW = $clog2(FRAME_SIZE*NLSB+1);
  logic [DW-1:0]                diff_q, diff_d;
  logic [DW-1:0]                out_diff_q, out_diff_d;
`endif

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      work_q      <= '0;
      msg_q       <= '0;
      out_frame_q <= '0;
      out_msg_q   <= '0;
`ifdef LSB_STEGO_DIFFCNT_EN
      diff_q      <= '0;
      out_diff_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      work_q      <= work_d;
      msg_q       <= msg_d;
      out_frame_q <= out_frame_d;
      out_msg_q   <= out_msg_d;
`ifdef LSB_STEGO_DIFFCNT_EN
      diff_q      <= diff_d;
      out_diff_q  <= out_diff_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    work_d      = work_q;
    msg_d       = msg_q;
    out_frame_d = out_frame_q;
    out_msg_d   = out_msg_q;
`ifdef LSB_STEGO_DIFFCNT_EN
    diff_d      = diff_q;
    out_diff_d  = out_diff_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (in_enable) begin
          state_d = S_PROC;
          idx_d   = '0;
          mode_d  = in_mode;
          work_d  = in_frame;
          msg_d   = in_message;
`ifdef LSB_STEGO_DIFFCNT_EN
          diff_d  = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PROC: begin
        for (int i = 0; i < FRAME_SIZE; i++) begin
          if (idx_q == IW'(i)) begin
            if (mode_q) begin
              msg_d[i*NLSB +: NLSB] = work_q[i*BPS +: NLSB];
            end else begin
              work_d[i*BPS +: NLSB] = msg_q[i*NLSB +: NLSB];
`ifdef LSB_STEGO_DIFFCNT_EN
              for (int b = 0; b < NLSB; b++) begin
                diff_d = diff_d + DW'(work_q[i*BPS+b] ^ msg_q[i*NLSB+b]);
              end
`endif
            end
          end
        end
        // Last sample: publish the results including the sample processed this edge.
        if (idx_q == LAST) begin
          state_d     = S_DONE;
          idx_d       = '0;
          out_frame_d = work_d;
          out_msg_d   = msg_d;
`ifdef LSB_STEGO_DIFFCNT_EN
          out_diff_d  = mode_q ? '0 : diff_d;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_frame   = out_frame_q;
  assign out_message = out_msg_q;
  assign out_ready   = (state_q == S_DONE);
  assign out_busy    = (state_q == S_PROC);
`ifdef LSB_STEGO_DIFFCNT_EN
  assign out_diff_cnt = out_diff_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsb_stego_seq.sv
// Directed self-checking bench for lsb_stego_seq (4x8 bit / 2 LSB and 1x8 bit / 1 LSB builds).
`default_nettype none

module tb_lsb_stego_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en_a = 1'b0, mode_a = 1'b0;
  logic [31:0] frame_a = 32'hDEAD_BEEF;
  logic [7:0]  msg_a = 8'h00;
  logic [31:0] oframe_a;
  logic [7:0]  omsg_a;
  logic        ready_a, busy_a;

  logic        en_b = 1'b0, mode_b = 1'b0;
  logic [7:0]  frame_b = 8'h00;
  logic [0:0]  msg_b = 1'b0;
  logic [7:0]  oframe_b;
  logic [0:0]  omsg_b;
  logic        ready_b, busy_b;

`ifdef LSB_STEGO_DIFFCNT_EN
  logic [3:0]  diff_a;
  logic [0:0]  diff_b;
`endif

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  lsb_stego_seq #(.FRAME_SIZE(4), .BPS(8), .NLSB(2)) dut_a (
    .in_clk(clk), .in_rst_n(rst_n), .in_enable(en_a), .in_mode(mode_a),
    .in_frame(frame_a), .in_message(msg_a), .out_frame(oframe_a),
    .out_message(omsg_a), .out_ready(ready_a),
`ifdef LSB_STEGO_DIFFCNT_EN
    .out_diff_cnt(diff_a),
`endif
    .out_busy(busy_a)
  );

  lsb_stego_seq #(.FRAME_SIZE(1), .BPS(8), .NLSB(1)) dut_b (
    .in_clk(clk), .in_rst_n(rst_n), .in_enable(en_b), .in_mode(mode_b),
    .in_frame(frame_b), .in_message(msg_b), .out_frame(oframe_b),
    .out_message(omsg_b), .out_ready(ready_b),
`ifdef LSB_STEGO_DIFFCNT_EN
    .out_diff_cnt(diff_b),
`endif
    .out_busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held across a few edges
    step(); step();
    check("rst_frame", oframe_a, 32'h0);
    check("rst_ready", ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    step();
    check("idle_ready", ready_a, 1'b0);
    check("idle_msg", omsg_a, 8'h0);

    // Embed
    frame_a = 32'hA5_3C_FF_00; msg_a = 8'h9C; mode_a = 1'b0; en_a = 1'b1;
    step();                                   // E0
    en_a = 1'b0;
    check("emb_busy_e0", busy_a, 1'b1);
    check("emb_ready_e0", ready_a, 1'b0);
    step(); step(); step();                   // E1..E3
    check("emb_ready_e3", ready_a, 1'b0);
    check("emb_frame_e3", oframe_a, 32'h0);
    step();                                   // E4
    check("emb_ready", ready_a, 1'b1);
    check("emb_busy_done", busy_a, 1'b0);
    check("emb_frame", oframe_a, 32'hA6_3D_FF_00);
    check("emb_msg", omsg_a, 8'h9C);
`ifdef LSB_STEGO_DIFFCNT_EN
    check("emb_diff", diff_a, 4'd3);
`endif
    step();
    check("emb_idle_ready", ready_a, 1'b0);
    check("emb_idle_busy", busy_a, 1'b0);
    check("emb_hold_frame", oframe_a, 32'hA6_3D_FF_00);

    // Extract, with input disturbance and enable pulse during PROC
    frame_a = 32'hA6_3D_FF_00; msg_a = 8'h55; mode_a = 1'b1; en_a = 1'b1;
    step();                                   // E0
    frame_a = 32'h0; msg_a = 8'h00; mode_a = 1'b0;
    step();                                   // E1, enable ignored
    en_a = 1'b0;
    step(); step();
    check("ext_ready_e3", ready_a, 1'b0);
    step();                                   // E4
    check("ext_ready", ready_a, 1'b1);
    check("ext_msg", omsg_a, 8'h9C);
    check("ext_frame", oframe_a, 32'hA6_3D_FF_00);
`ifdef LSB_STEGO_DIFFCNT_EN
    check("ext_diff", diff_a, 4'd0);
`endif
    step();
    check("ext_no_extra_busy", busy_a, 1'b0);
    check("ext_no_extra_ready", ready_a, 1'b0);
    step();
    check("ext_no_extra_busy2", busy_a, 1'b0);

    // Back-to-back: 12_34_56_78 with FF -> 13_37_57_7B, 6 differing bits
    frame_a = 32'h12_34_56_78; msg_a = 8'hFF; mode_a = 1'b0; en_a = 1'b1;
    step();
    en_a = 1'b0;
    step(); step(); step(); step();
    check("b2b_ready1", ready_a, 1'b1);
    check("b2b_frame1", oframe_a, 32'h13_37_57_7B);
`ifdef LSB_STEGO_DIFFCNT_EN
    check("b2b_diff1", diff_a, 4'd6);
`endif
    frame_a = 32'hA5_3C_FF_00; msg_a = 8'h9C; mode_a = 1'b0; en_a = 1'b1;
    step();
    en_a = 1'b0;
    n = 1;
    check("b2b_busy", busy_a, 1'b1);
    check("b2b_hold", oframe_a, 32'h13_37_57_7B);
    while (!ready_a && n < 10) begin
      step();
      n++;
    end
    check("b2b_spacing", n, 5);
    check("b2b_frame2", oframe_a, 32'hA6_3D_FF_00);
`ifdef LSB_STEGO_DIFFCNT_EN
    check("b2b_diff2", diff_a, 4'd3);
`endif
    step();

    // Asynchronous reset at index 2
    frame_a = 32'h12_34_56_78; msg_a = 8'hFF; mode_a = 1'b0; en_a = 1'b1;
    step();                                   // E0
    en_a = 1'b0;
    step(); step();                           // index now 2
    check("rst_mid_busy_before", busy_a, 1'b1);
    rst_n = 1'b0;
    #2;
    check("rst_async_frame", oframe_a, 32'h0);
    check("rst_async_msg", omsg_a, 8'h0);
    check("rst_async_busy", busy_a, 1'b0);
    check("rst_async_ready", ready_a, 1'b0);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst_no_ready", ready_a, 1'b0);
    end
    check("rst_idle_busy", busy_a, 1'b0);

    // First enable after reset is the capture edge
    frame_a = 32'hA6_3D_FF_00; mode_a = 1'b1; en_a = 1'b1;
    step();
    en_a = 1'b0;
    step(); step(); step();
    check("post_rst_e3", ready_a, 1'b0);
    step();
    check("post_rst_ready", ready_a, 1'b1);
    check("post_rst_msg", omsg_a, 8'h9C);

    // FRAME_SIZE=1, NLSB=1
    frame_b = 8'hFE; msg_b = 1'b1; mode_b = 1'b0; en_b = 1'b1;
    step();
    en_b = 1'b0;
    check("fs1_busy", busy_b, 1'b1);
    check("fs1_ready_e0", ready_b, 1'b0);
    step();
    check("fs1_ready", ready_b, 1'b1);
    check("fs1_frame", oframe_b, 8'hFF);
    check("fs1_msg", omsg_b, 1'b1);
`ifdef LSB_STEGO_DIFFCNT_EN
    check("fs1_diff", diff_b, 1'b1);
`endif
    step();
    check("fs1_idle", ready_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
